// File: rtl/mprj_wb_responder.sv
// ---------------------------------------------------------------------------
// mprj_wb_responder : Wishbone classic user-project slave with scratch RAM,
// control/doorbell registers, programmable wait states and a doorbell IRQ.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mprj_wb_responder #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter logic [31:0] ADR_MASK = 32'hFFFF_FFC0,
  parameter logic [3:0]  RESET_WS = 4'd0
) (
  input  logic        core_clk,
  input  logic        core_rst,
  input  logic        wb_iena,
  input  logic        mprj_cyc_i,
  input  logic        mprj_stb_i,
  input  logic        mprj_we_i,
  input  logic [3:0]  mprj_sel_i,
  input  logic [31:0] mprj_adr_i,
  input  logic [31:0] mprj_dat_i,
  output logic        mprj_ack_o,
  output logic [31:0] mprj_dat_o,
  output logic        user_irq,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACK = 2'd2} state_t;

  localparam logic [3:0] IDX_CTRL = 4'd14;
  localparam logic [3:0] IDX_DB   = 4'd15;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        req, ld, commit;

  logic        hit_q, we_q;
  logic [3:0]  idx_q, sel_q;
  logic [31:0] dat_q;

  logic        live_hit;
  logic        c_hit, c_we;
  logic [3:0]  c_idx, c_sel;
  logic [31:0] c_dat, rdata;

  logic [3:0]  ws;
  logic        irq_en, err, pending;
  logic [31:0] db;
  logic [31:0] mem [0:13];

  assign req      = mprj_cyc_i & mprj_stb_i & wb_iena;
  assign live_hit = (mprj_adr_i & ADR_MASK) == (BASE_ADR & ADR_MASK);
  assign busy     = (state != S_IDLE);

  // A zero-wait commit happens on the sampling edge itself, so it must use
  // the live bus; otherwise the request latched in IDLE is used.
  assign c_hit = (state == S_IDLE) ? live_hit          : hit_q;
  assign c_we  = (state == S_IDLE) ? mprj_we_i         : we_q;
  assign c_idx = (state == S_IDLE) ? mprj_adr_i[5:2]   : idx_q;
  assign c_sel = (state == S_IDLE) ? mprj_sel_i        : sel_q;
  assign c_dat = (state == S_IDLE) ? mprj_dat_i        : dat_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ld        = 1'b0;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          ld      = 1'b1;
          cnt_nxt = ws;
          if (ws == 4'd0) begin
            commit    = 1'b1;
            state_nxt = S_ACK;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!mprj_cyc_i) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) begin
            commit    = 1'b1;
            state_nxt = S_ACK;
          end
        end
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rdata = 32'd0;
    if (c_hit && !c_we) begin
      if (c_idx == IDX_CTRL)    rdata = {15'd0, err, 7'd0, irq_en, 4'd0, ws};
      else if (c_idx == IDX_DB) rdata = db;
      else                      rdata = mem[c_idx];
    end
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      hit_q      <= 1'b0;
      we_q       <= 1'b0;
      idx_q      <= 4'd0;
      sel_q      <= 4'd0;
      dat_q      <= 32'd0;
      mprj_ack_o <= 1'b0;
      mprj_dat_o <= 32'd0;
      user_irq   <= 1'b0;
      ws         <= RESET_WS;
      irq_en     <= 1'b0;
      err        <= 1'b0;
      db         <= 32'd0;
      pending    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      mprj_ack_o <= commit;
      mprj_dat_o <= commit ? rdata : 32'd0;
      user_irq   <= pending & irq_en;
      if (ld) begin
        hit_q <= live_hit;
        we_q  <= mprj_we_i;
        idx_q <= mprj_adr_i[5:2];
        sel_q <= mprj_sel_i;
        dat_q <= mprj_dat_i;
      end
      if (commit) begin
        if (!c_hit) begin
          err <= 1'b1;
        end else if (c_we) begin
          if (c_idx == IDX_CTRL) begin
            ws     <= c_dat[3:0];
            irq_en <= c_dat[8];
            if (c_dat[16]) err <= 1'b0;
          end else if (c_idx == IDX_DB) begin
            db      <= c_dat;
            pending <= 1'b1;
          end
        end else if (c_idx == IDX_DB) begin
          pending <= 1'b0;
        end
      end
    end
  end

  // Scratch RAM is deliberately left out of reset.
  always_ff @(posedge core_clk) begin
    if (commit && c_hit && c_we && (c_idx < IDX_CTRL)) begin
      for (int b = 0; b < 4; b++) begin
        if (c_sel[b]) mem[c_idx][8*b +: 8] <= c_dat[8*b +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/mprj_wb_responder.md
Name: mprj_wb_responder

Overview:
User-project-side Wishbone classic (B3) slave: the responder end of the management SoC's exported user-project bus.
- Decodes one address window and serves 14 scratch RAM words, a control register and a doorbell register.
- Inserts programmable wait states.
- Raises a user IRQ line back toward the SoC's user IRQ inputs.
- Serves as the reference user-area target for bus bring-up and firmware tests.

Parameters:
BASE_ADR, 32'h3000_0000, base of the decoded window.
ADR_MASK, 32'hFFFF_FFC0, bits compared against BASE_ADR; window is 64 bytes (16 words).
RESET_WS, 0, reset value of CTRL wait-state field (0-15).

Ports:
core_clk  input  1  single clock for all logic.
core_rst  input  1  asynchronous, active-high reset.
wb_iena  input  1  bus return enable; when low, no request is accepted.
mprj_cyc_i  input  1  Wishbone cycle.
mprj_stb_i  input  1  Wishbone strobe.
mprj_we_i  input  1  write enable.
mprj_sel_i  input  4  byte selects.
mprj_adr_i  input  32  byte address; word index is adr[5:2].
mprj_dat_i  input  32  write data.
mprj_ack_o  output  1  acknowledge, registered.
mprj_dat_o  output  32  read data, valid only while ack=1, otherwise 0.
user_irq  output  1  doorbell interrupt, level.
busy  output  1  high in any state other than IDLE.

Behaviour:
Reset values:
- ack=0, dat_o=0, user_irq=0, busy=0, FSM=IDLE.
- CTRL = {err=0, irq_en=0, ws=RESET_WS}; doorbell latch=0; pending=0.
- RAM contents are not reset; the bench must write before reading.

Register map (word index):
- 0-13: RAM, byte-writable via sel.
- 14: CTRL — [3:0] ws, [8] irq_en, [16] err (sticky, write-1-to-clear; write 0 leaves it unchanged). Other bits read 0.
- 15: DOORBELL — write stores the full 32-bit value (sel ignored) and sets pending; read returns the latched value and clears pending.

FSM states: IDLE, WAIT, ACK.
- IDLE: on an edge where cyc&stb&wb_iena=1, latch adr/we/sel/dat and load cnt=ws.
  - If ws=0, go to ACK; otherwise go to WAIT.
- WAIT: each cycle, if cyc=0, abort to IDLE (no write, no ack, no side effects). Otherwise decrement cnt; when cnt reaches 1→0, go to ACK.
- ACK: ack=1 for exactly one cycle, then IDLE. The write commit and read-side effects occur on the edge entering ACK. dat_o is driven during ACK.
- Latency: ack is high in cycle 1+ws after the sampled request cycle. Back-to-back requests are spaced at least ws+2 cycles apart (IDLE must re-sample).

Decode and window rules:
- Hit when (adr & ADR_MASK) == (BASE_ADR & ADR_MASK).
- Miss: the cycle is still acked with normal timing, read data=0, the write is dropped, and err is set.
- A CTRL write changing ws affects the next transaction only.

IRQ and doorbell:
- user_irq = pending & irq_en, registered from the state after commit.
- Doorbell write and read in the same transaction cannot occur. A new doorbell write while pending=1 overwrites the latch and keeps pending=1.

Other rules:
- wb_iena low mid-transaction has no effect on an accepted transaction; it only blocks acceptance in IDLE.
- core_rst asserted mid-transaction: immediate return to reset values. A write not yet committed is lost; a committed write is kept.

Test Plan:
1. Write RAM[3]=32'hA5A5_1234 with sel=4'hF, ws=0, then read → ack 1 cycle after stb is sampled; read data 32'hA5A5_1234.
2. Write RAM[3] with sel=4'b0010 and dat=32'h0000_FF00 over 32'hA5A5_1234 → readback 32'hA5A5_FF34.
3. CTRL=0x0000_0103 (ws=3, irq_en=1), then read RAM[0] → ack in cycle 4; busy high for cycles 1-4.
4. With ws=3, drop cyc in cycle 2 during a RAM[1] write → no ack; RAM[1] unchanged; FSM in IDLE; next transaction normal.
5. Write DOORBELL=32'hCAFE_0001 with irq_en=1 → user_irq=1 the cycle after ack. Read DOORBELL → returns 32'hCAFE_0001 and user_irq=0 after that ack. With irq_en=0, user_irq stays 0.
6. Access 0x3000_0040 (miss) → acked, read data 0, CTRL[16]=1. Write CTRL with bit16=1 → err=0. Assert core_rst during WAIT → ack=0, busy=0, CTRL ws=RESET_WS.
